// File: rtl/mc_adc_pkg.sv
// Shared definitions for the multi-channel serial ADC readout.
// Holds:
//   - the acquisition state type
//   - the width of the sample-set counter
//   - the bit-counter width helper
package mc_adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int SAMPLE_CNT_W = 16;

   // The bit counter must be able to hold SAMPLE_BITS itself,
   // because the final high phase runs after the last bit is counted.
   function automatic int bit_cnt_width(input int sample_bits);
      return $clog2(sample_bits + 1);
   endfunction

endpackage

// File: rtl/mc_adc_sclk_gen.sv
// Serial clock generator for the ADC interface.
// The counter divides clk into SCLK half-periods of CLK_DIV cycles each.
// Ports:
//   clk, rst   : system clock and asynchronous active-high reset
//   en         : run the divider; when low, SCLK parks high and the counter
//                is primed so the next enabled cycle immediately falls
//   sclk       : registered SCLK level
//   rise_stb   : this cycle ends a low phase (SCLK goes 0->1 on the next edge)
//   fall_stb   : this cycle ends a high phase (SCLK goes 1->0 on the next edge)
//   phase_end  : current half-period is in its last cycle (independent of en)
module mc_adc_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise_stb,
   output logic fall_stb,
   output logic phase_end
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt_reg;
   logic             sclk_reg;

   assign phase_end = (div_cnt_reg == CNT_LAST);
   assign rise_stb  = en && !sclk_reg && phase_end;
   assign fall_stb  = en &&  sclk_reg && phase_end;
   assign sclk      = sclk_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_reg <= CNT_LAST;
         sclk_reg    <= 1'b1;
      end else if (!en) begin
         div_cnt_reg <= CNT_LAST;
         sclk_reg    <= 1'b1;
      end else if (phase_end) begin
         div_cnt_reg <= '0;
         sclk_reg    <= ~sclk_reg;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mc_adc_readout.sv
// Multi-channel serial ADC acquisition engine.
// The engine drives one shared CS_N and one shared SCLK to NUM_CH ADCs.
// It shifts one SAMPLE_BITS sample per channel in parallel.
// The packed set goes out through a single-entry valid/ready output register.
// Ports:
//   CLK, RST          : system clock, asynchronous active-high reset
//   START, CONT, ABORT: conversion request, continuous mode, abort
//   ADC_SCLK, ADC_CS_N: registered serial clock (idle high) and chip select
//   ADC_SDO           : per-channel serial data, MSB first
//   DATA_OUT          : channel c at [c*SAMPLE_BITS +: SAMPLE_BITS]
//   DATA_VALID/READY  : output handshake
//   BUSY              : engine not idle
//   OVERFLOW, CLR_OVF : sticky dropped-set flag and its clear
//   SAMPLE_CNT        : number of sets loaded into DATA_OUT (wraps)
module mc_adc_readout
   import mc_adc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SAMPLE_BITS = 16,
   parameter int CLK_DIV     = 4,
   parameter int CS_SETUP    = 2,
   parameter int QUIET       = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          START,
   input  logic                          CONT,
   input  logic                          ABORT,
   output logic                          ADC_SCLK,
   output logic                          ADC_CS_N,
   input  logic [NUM_CH-1:0]             ADC_SDO,
   output logic [NUM_CH*SAMPLE_BITS-1:0] DATA_OUT,
   output logic                          DATA_VALID,
   input  logic                          DATA_READY,
   output logic                          BUSY,
   output logic                          OVERFLOW,
   input  logic                          CLR_OVF,
   output logic [SAMPLE_CNT_W-1:0]       SAMPLE_CNT
);

   localparam int BIT_W  = bit_cnt_width(SAMPLE_BITS);
   localparam int PH_MAX = (CS_SETUP > QUIET) ? CS_SETUP : QUIET;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
   localparam logic [PH_W-1:0]  QUIET_LAST = PH_W'(QUIET - 1);
   localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(SAMPLE_BITS);

   state_t                          state_reg;
   logic                            cs_n_reg;
   logic                            busy_reg;
   logic [PH_W-1:0]                 phase_cnt_reg;
   logic [BIT_W-1:0]                bit_cnt_reg;
   logic [NUM_CH*SAMPLE_BITS-1:0]   data_out_reg;
   logic                            data_valid_reg;
   logic                            overflow_reg;
   logic [SAMPLE_CNT_W-1:0]         sample_cnt_reg;
   logic [NUM_CH*SAMPLE_BITS-1:0]   sample_set;

   logic sclk, rise_stb, fall_stb, phase_end;
   logic sclk_en, shift_done, abort_now, load_ev, load_ok;

   assign abort_now  = ABORT && (state_reg != IDLE);
   // The conversion ends at the last cycle of the high phase following the final bit.
   assign shift_done = (state_reg == SHIFT) && (bit_cnt_reg == BITS_ALL) && sclk && phase_end;
   // The divider runs from the last SETUP cycle, so that SCLK is already low
   // in the first SHIFT cycle.
   // It stops on the final SHIFT cycle so that SCLK stays parked high into HOLD.
   assign sclk_en    = !abort_now &&
                       (((state_reg == SETUP) && (phase_cnt_reg == SETUP_LAST)) ||
                        ((state_reg == SHIFT) && !shift_done));
   assign load_ev    = shift_done && !abort_now;
   assign load_ok    = !data_valid_reg || DATA_READY;

   mc_adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk       (CLK),
      .rst       (RST),
      .en        (sclk_en),
      .sclk      (sclk),
      .rise_stb  (rise_stb),
      .fall_stb  (fall_stb),
      .phase_end (phase_end)
   );

   // One shift register per channel.
   // Each captures on the edge where SCLK goes 0->1.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [SAMPLE_BITS-1:0] shift_reg;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST)
               shift_reg <= '0;
            else if (rise_stb)
               shift_reg <= {shift_reg[SAMPLE_BITS-2:0], ADC_SDO[gi]};
         end
         assign sample_set[gi*SAMPLE_BITS +: SAMPLE_BITS] = shift_reg;
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= IDLE;
         cs_n_reg      <= 1'b1;
         busy_reg      <= 1'b0;
         phase_cnt_reg <= '0;
         bit_cnt_reg   <= '0;
      end else if (abort_now) begin
         state_reg <= IDLE;
         cs_n_reg  <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (START) begin
               state_reg     <= SETUP;
               cs_n_reg      <= 1'b0;
               busy_reg      <= 1'b1;
               phase_cnt_reg <= '0;
            end
            SETUP: if (fall_stb) begin
               state_reg   <= SHIFT;
               bit_cnt_reg <= '0;
            end else begin
               phase_cnt_reg <= phase_cnt_reg + 1'b1;
            end
            SHIFT: begin
               if (rise_stb)
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               if (shift_done) begin
                  state_reg     <= HOLD;
                  cs_n_reg      <= 1'b1;
                  phase_cnt_reg <= '0;
               end
            end
            HOLD: if (phase_cnt_reg == QUIET_LAST) begin
               if (CONT) begin
                  state_reg     <= SETUP;
                  cs_n_reg      <= 1'b0;
                  phase_cnt_reg <= '0;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end else begin
               phase_cnt_reg <= phase_cnt_reg + 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Single-entry output register.
   // A completed set that finds it occupied and not being read is dropped.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         sample_cnt_reg <= '0;
      end else begin
         if (load_ev && load_ok) begin
            data_out_reg   <= sample_set;
            data_valid_reg <= 1'b1;
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
         end else if (data_valid_reg && DATA_READY) begin
            data_valid_reg <= 1'b0;
         end
         if (load_ev && !load_ok)
            overflow_reg <= 1'b1;
         else if (CLR_OVF)
            overflow_reg <= 1'b0;
      end
   end

   assign ADC_SCLK   = sclk;
   assign ADC_CS_N   = cs_n_reg;
   assign BUSY       = busy_reg;
   assign DATA_OUT   = data_out_reg;
   assign DATA_VALID = data_valid_reg;
   assign OVERFLOW   = overflow_reg;
   assign SAMPLE_CNT = sample_cnt_reg;

endmodule

// File: tb/tb_mc_adc_readout.sv
// Self-checking bench for mc_adc_readout.
// A behavioural ADC model serves one planned word per conversion.
// Stimulus pushes the sets it expects to be delivered into a scoreboard queue.
// A monitor pops and compares on every DATA_VALID & DATA_READY handshake.
module tb_mc_adc_readout;

   localparam int NUM_CH = 2, SB = 8, CLK_DIV = 2, CS_SETUP = 1, QUIET = 2;
   localparam int W = NUM_CH * SB;

   logic clk = 1'b0;
   logic rst, start, cont, abort_i, data_ready, clr_ovf;
   logic [NUM_CH-1:0] adc_sdo;
   logic adc_sclk, adc_cs_n, data_valid, busy, overflow;
   logic [W-1:0] data_out;
   logic [15:0] sample_cnt;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] adc_q[$];
   int gap_q[$];
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   mc_adc_readout #(
      .NUM_CH(NUM_CH), .SAMPLE_BITS(SB), .CLK_DIV(CLK_DIV),
      .CS_SETUP(CS_SETUP), .QUIET(QUIET)
   ) dut (
      .CLK(clk), .RST(rst), .START(start), .CONT(cont), .ABORT(abort_i),
      .ADC_SCLK(adc_sclk), .ADC_CS_N(adc_cs_n), .ADC_SDO(adc_sdo),
      .DATA_OUT(data_out), .DATA_VALID(data_valid), .DATA_READY(data_ready),
      .BUSY(busy), .OVERFLOW(overflow), .CLR_OVF(clr_ovf), .SAMPLE_CNT(sample_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ADC model: a new word is taken when CS_N falls.
   // Each SCLK falling edge presents the next bit, MSB first.
   logic [W-1:0] adc_word;
   int adc_bit;
   bit adc_loaded = 1'b0;
   initial adc_sdo = '0;
   always @(negedge adc_sclk or negedge adc_cs_n or posedge adc_cs_n) begin
      if (adc_cs_n === 1'b1) begin
         adc_loaded = 1'b0;
      end else if (!adc_loaded) begin
         if (adc_q.size() > 0) adc_word = adc_q.pop_front();
         else                  adc_word = W'($urandom);
         adc_bit    = SB - 1;
         adc_loaded = 1'b1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) adc_sdo[c] = adc_word[c*SB + adc_bit];
         if (adc_bit > 0) adc_bit--;
      end
   end

   // Monitor: compare every delivered set against the scoreboard.
   always @(negedge clk) begin
      #2;
      if (rst === 1'b0 && data_valid === 1'b1 && data_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_set actual=%0h required=none", data_out);
         end else begin
            check("sample_set", data_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_sclk"},  adc_sclk, 1);
      check({tag, "_cs_n"},  adc_cs_n, 1);
      check({tag, "_dout"},  data_out, 0);
      check({tag, "_valid"}, data_valid, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_ovf"},   overflow, 0);
      check({tag, "_cnt"},   sample_cnt, 0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(name, busy, 0);
   endtask

   task automatic single_conv(input string name);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle(name);
   endtask

   // Continuous run.
   // CONT drops once the n-th conversion has started.
   // The CS_N high gaps between conversions are recorded in gap_q.
   task automatic conv_cont(input int n, input string name);
      bit prev = 1'b1;
      int falls = 0, hi_run = 0;
      gap_q.delete();
      cont = 1'b1;
      @(negedge clk); start = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (prev && !adc_cs_n) begin
            falls++;
            if (falls > 1) gap_q.push_back(hi_run);
            hi_run = 0;
            if (falls == n) cont = 1'b0;
         end else if (adc_cs_n && falls > 0) begin
            hi_run++;
         end
         prev = adc_cs_n;
         if (falls == n && busy == 1'b0) break;
      end
      cont = 1'b0;
      check({name, "_conversions"}, falls, n);
      check({name, "_idle"}, busy, 0);
   endtask

   logic cs_s[0:40], sclk_s[0:40], val_s[0:40], busy_s[0:40];
   logic [W-1:0] w1, w2, wg;
   logic [15:0] cnt_before;

   initial begin
      rst = 1'b1; start = 0; cont = 0; abort_i = 0; data_ready = 1'b1; clr_ovf = 0;
      exp_cnt = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single shot with fixed data and exact timing.
      adc_q.push_back(16'h3CA5);
      exp_q.push_back(16'h3CA5);
      exp_cnt++;
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 38; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         cs_s[cyc] = adc_cs_n; sclk_s[cyc] = adc_sclk;
         val_s[cyc] = data_valid; busy_s[cyc] = busy;
      end
      begin
         int lo_first = -1, lo_last = -1, lo_n = 0, rises = 0, v_first = -1;
         for (int cyc = 1; cyc <= 38; cyc++) begin
            if (cs_s[cyc] === 1'b0) begin
               if (lo_first < 0) lo_first = cyc;
               lo_last = cyc;
               lo_n++;
            end
            if (cyc > 1 && sclk_s[cyc-1] === 1'b0 && sclk_s[cyc] === 1'b1) rises++;
            if (v_first < 0 && val_s[cyc] === 1'b1) v_first = cyc;
         end
         check("t1_cs_first_low", lo_first, 1);
         check("t1_cs_last_low", lo_last, 33);
         check("t1_cs_low_cycles", lo_n, 33);
         check("t1_sclk_rises", rises, SB);
         check("t1_valid_cycle", v_first, 34);
         check("t1_busy_c35", busy_s[35], 1);
         check("t1_busy_c37", busy_s[37], 0);
         check("t1_cnt", sample_cnt, exp_cnt);
      end

      // 2: continuous mode, READY held high, words 0x01..0x04 per channel.
      for (int k = 1; k <= 4; k++) begin
         logic [7:0] b;
         b = 8'(k);
         adc_q.push_back({b, b});
         exp_q.push_back({b, b});
         exp_cnt++;
      end
      conv_cont(4, "t2");
      check("t2_gap_count", gap_q.size(), 3);
      foreach (gap_q[i]) check("t2_cs_gap", gap_q[i], QUIET);
      repeat (3) @(negedge clk);
      check("t2_cnt", sample_cnt, exp_cnt);
      check("t2_ovf", overflow, 0);
      check("t2_drained", exp_q.size(), 0);

      // 3: backpressure; the second set must be dropped.
      data_ready = 1'b0;
      w1 = W'($urandom); w2 = W'($urandom);
      adc_q.push_back(w1); adc_q.push_back(w2);
      exp_q.push_back(w1);
      exp_cnt++;
      conv_cont(2, "t3");
      check("t3_valid", data_valid, 1);
      check("t3_dout_kept", data_out, w1);
      check("t3_ovf", overflow, 1);
      check("t3_cnt", sample_cnt, exp_cnt);
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      check("t3_ovf_cleared", overflow, 0);
      data_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("t3_drained", exp_q.size(), 0);
      check("t3_valid_after", data_valid, 0);

      // 4: ABORT together with START during the fourth bit, then a clean conversion.
      adc_q.push_back(W'($urandom));
      wg = W'($urandom);
      adc_q.push_back(wg);
      cnt_before = sample_cnt;
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 15; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("t4_cs_before_abort", adc_cs_n, 0);
      check("t4_sclk_before_abort", adc_sclk, 0);
      abort_i = 1'b1; start = 1'b1;
      @(negedge clk);
      abort_i = 1'b0; start = 1'b0;
      check("t4_cs_n", adc_cs_n, 1);
      check("t4_sclk", adc_sclk, 1);
      check("t4_busy", busy, 0);
      check("t4_valid", data_valid, 0);
      begin
         int vhits = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b0 || busy !== 1'b0) vhits++;
         end
         check("t4_quiet_after_abort", vhits, 0);
      end
      check("t4_cnt_unchanged", sample_cnt, cnt_before);
      exp_q.push_back(wg);
      exp_cnt++;
      single_conv("t4_restart_idle");
      repeat (2) @(negedge clk);
      check("t4_cnt", sample_cnt, exp_cnt);
      check("t4_drained", exp_q.size(), 0);

      // 5: asynchronous reset in the middle of SHIFT.
      adc_q.push_back(W'($urandom));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      #3 rst = 1'b1;
      #1 check_reset_vals("t5");
      @(negedge clk); rst = 1'b0;
      exp_cnt = '0;
      begin
         int vhits = 0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b0) vhits++;
         end
         check("t5_no_spurious_valid", vhits, 0);
      end

      // 6: counter wrap, preloading the counter just below the top.
      @(negedge clk);
      dut.sample_cnt_reg = 16'hFFFE;
      exp_cnt = 16'hFFFE;
      for (int k = 0; k < 2; k++) begin
         w1 = W'($urandom);
         adc_q.push_back(w1);
         exp_q.push_back(w1);
         exp_cnt++;
         single_conv("t6_idle");
         repeat (2) @(negedge clk);
         check("t6_cnt", sample_cnt, exp_cnt);
      end
      check("t6_wrapped_zero", sample_cnt, 16'h0000);
      check("final_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
